// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared direction encodings, FSM state and intent types for the motor command block
package motor_pkg;

    localparam logic [1:0] DIR_FWD  = 2'b11;
    localparam logic [1:0] DIR_REV  = 2'b00;
    localparam logic [1:0] DIR_HALT = 2'b01;

    typedef enum logic [1:0] {
        ST_HALT,
        ST_FWD,
        ST_REV,
        ST_DEAD
    } state_e;

    typedef enum logic [1:0] {
        INT_HALT,
        INT_FWD,
        INT_REV
    } intent_e;

    function automatic logic [1:0] dir_of_state(input state_e s);
        case (s)
            ST_FWD:  return DIR_FWD;
            ST_REV:  return DIR_REV;
            default: return DIR_HALT;
        endcase
    endfunction

    // Contradictory requests resolve to halt, never to a direction.
    function automatic intent_e decode_intent(input logic fwd, input logic rev);
        if (fwd && !rev) return INT_FWD;
        if (rev && !fwd) return INT_REV;
        return INT_HALT;
    endfunction

endpackage

// File: rtl/motor_debounce.sv
// rtl/motor_debounce.sv - 2-flop synchronizer followed by a stability counter for one raw input
module motor_debounce #(
    parameter int DEB_CYCLES = 500
) (
    input  logic clk_100kHz,
    input  logic rst,
    input  logic din,
    output logic deb_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter tallies consecutive samples that disagree with the held value;
    // the last one of DEB_CYCLES flips the output, so it never exceeds CNT_LAST.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100kHz or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/motor_cmd_ctrl.sv
// rtl/motor_cmd_ctrl.sv - debounced fwd/rev motor command FSM with reversal dead time; MOTOR_WATCHDOG_EN adds a keepalive watchdog
module motor_cmd_ctrl
    import motor_pkg::*;
#(
    parameter int DEB_CYCLES  = 500,
    parameter int DEAD_CYCLES = 20000,
    parameter int WDT_CYCLES  = 100000
) (
    input  logic       clk_100kHz,
    input  logic       rst,
    input  logic       fwd_req,
    input  logic       rev_req,
    input  logic       kick,
    output logic [1:0] direction,
    output logic       dead_active,
    output logic       wdt_trip
);

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

    logic              fwd_deb, rev_deb;
    intent_e           intent;
    state_e            state_q, state_d;
    logic              target_rev_q, target_rev_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [1:0]        direction_q, direction_d;
    logic              dead_active_q, dead_active_d;
    logic              wdt_expired;
    logic              lockout;

    motor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fwd (
        .clk_100kHz (clk_100kHz),
        .rst        (rst),
        .din        (fwd_req),
        .deb_o      (fwd_deb)
    );

    motor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rev (
        .clk_100kHz (clk_100kHz),
        .rst        (rst),
        .din        (rev_req),
        .deb_o      (rev_deb)
    );

    always_comb begin
        intent        = decode_intent(fwd_deb, rev_deb);
        state_d       = state_q;
        target_rev_d  = target_rev_q;
        dead_cnt_d    = dead_cnt_q;
        direction_d   = dir_of_state(state_q);
        dead_active_d = (state_q == ST_DEAD);
        case (state_q)
            ST_HALT: begin
                if (!lockout && intent == INT_FWD)      state_d = ST_FWD;
                else if (!lockout && intent == INT_REV) state_d = ST_REV;
            end
            ST_FWD: begin
                if (wdt_expired || intent == INT_HALT) begin
                    state_d = ST_HALT;
                end else if (intent == INT_REV) begin
                    state_d      = ST_DEAD;
                    target_rev_d = 1'b1;
                    dead_cnt_d   = DEAD_LOAD;
                end
            end
            ST_REV: begin
                if (wdt_expired || intent == INT_HALT) begin
                    state_d = ST_HALT;
                end else if (intent == INT_FWD) begin
                    state_d      = ST_DEAD;
                    target_rev_d = 1'b0;
                    dead_cnt_d   = DEAD_LOAD;
                end
            end
            ST_DEAD: begin
                // Exit goes through HALT so intent is re-read only after the full dead time.
                if (dead_cnt_q == '0) state_d = ST_HALT;
                else                  dead_cnt_d = dead_cnt_q - 1'b1;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk_100kHz or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HALT;
            target_rev_q  <= 1'b0;
            dead_cnt_q    <= '0;
            direction_q   <= DIR_HALT;
            dead_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_rev_q  <= target_rev_d;
            dead_cnt_q    <= dead_cnt_d;
            direction_q   <= direction_d;
            dead_active_q <= dead_active_d;
        end
    end

    assign direction   = direction_q;
    assign dead_active = dead_active_q;

`ifdef MOTOR_WATCHDOG_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES - 1);

    logic             kick_deb;
    logic             kick_prev_q, kick_prev_d;
    logic             trip_q, trip_d;
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             moving, entering;

    motor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_kick (
        .clk_100kHz (clk_100kHz),
        .rst        (rst),
        .din        (kick),
        .deb_o      (kick_deb)
    );

    assign moving      = (state_q == ST_FWD) || (state_q == ST_REV);
    assign wdt_expired = moving && (wdt_cnt_q == '0);
    assign lockout     = trip_q;

    always_comb begin
        entering    = ((state_d == ST_FWD) || (state_d == ST_REV)) && (state_d != state_q);
        kick_prev_d = kick_deb;
        wdt_cnt_d   = wdt_cnt_q;
        trip_d      = trip_q;
        if ((kick_deb && !kick_prev_q) || entering) wdt_cnt_d = WDT_LOAD;
        else if (moving && wdt_cnt_q != '0)         wdt_cnt_d = wdt_cnt_q - 1'b1;
        if (wdt_expired)              trip_d = 1'b1;
        else if (intent == INT_HALT)  trip_d = 1'b0;
    end

    always_ff @(posedge clk_100kHz or posedge rst) begin
        if (rst) begin
            kick_prev_q <= 1'b0;
            trip_q      <= 1'b0;
            wdt_cnt_q   <= WDT_LOAD;
        end else begin
            kick_prev_q <= kick_prev_d;
            trip_q      <= trip_d;
            wdt_cnt_q   <= wdt_cnt_d;
        end
    end

    assign wdt_trip = trip_q;
`else
    localparam int UNUSED_WDT_CYCLES = WDT_CYCLES;
    logic unused_kick;

    assign unused_kick = kick;
    assign wdt_expired = 1'b0;
    assign lockout     = 1'b0;
    assign wdt_trip    = 1'b0;
`endif

endmodule

// File: tb/tb_motor_cmd_ctrl.sv
// tb/tb_motor_cmd_ctrl.sv - directed self-checking bench for motor_cmd_ctrl (DEB=4, DEAD=10, WDT=50)
module tb_motor_cmd_ctrl;

    logic       clk_100kHz = 1'b0;
    logic       rst = 1'b1;
    logic       fwd_req = 1'b0;
    logic       rev_req = 1'b0;
    logic       kick = 1'b0;
    logic [1:0] direction;
    logic       dead_active;
    logic       wdt_trip;

    int tests  = 0;
    int failed = 0;

    motor_cmd_ctrl #(
        .DEB_CYCLES  (4),
        .DEAD_CYCLES (10),
        .WDT_CYCLES  (50)
    ) dut (
        .clk_100kHz  (clk_100kHz),
        .rst         (rst),
        .fwd_req     (fwd_req),
        .rev_req     (rev_req),
        .kick        (kick),
        .direction   (direction),
        .dead_active (dead_active),
        .wdt_trip    (wdt_trip)
    );

    always #5 clk_100kHz = ~clk_100kHz;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_100kHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic bad;

        // Reset state
        step(2);
        check("reset_dir", direction, 2'b01);
        check("reset_dead", {1'b0, dead_active}, 2'b00);
        check("reset_trip", {1'b0, wdt_trip}, 2'b00);
        rst = 1'b0;
        step(2);

        // Forward request: 8 cycles edge to output
        fwd_req = 1'b1;
        step(7);
        check("fwd_lat_7", direction, 2'b01);
        step(1);
        check("fwd_lat_8", direction, 2'b11);

        // Both requests in FWD: halt without dead time
        rev_req = 1'b1;
        bad = 1'b0;
        step(7);
        check("both_7", direction, 2'b11);
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (direction !== 2'b01 || dead_active !== 1'b0) bad = 1'b1;
        end
        check("both_halt_nodead", {1'b0, bad}, 2'b00);

        fwd_req = 1'b0;
        rev_req = 1'b0;
        step(10);
        check("idle_dir", direction, 2'b01);

        // Short pulses never pass the debouncer
        bad = 1'b0;
        for (int p = 0; p < 4; p++) begin
            fwd_req = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step(1);
                if (direction !== 2'b01) bad = 1'b1;
            end
            fwd_req = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step(1);
                if (direction !== 2'b01) bad = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (direction !== 2'b01) bad = 1'b1;
        end
        check("pulse_reject", {1'b0, bad}, 2'b00);

        // Forward, then reversal through DEAD
        fwd_req = 1'b1;
        step(8);
        check("fwd_again", direction, 2'b11);
        fwd_req = 1'b0;
        rev_req = 1'b1;
        step(7);
        check("rev_pre_dir", direction, 2'b11);
        check("rev_pre_dead", {1'b0, dead_active}, 2'b00);
        step(1);
        check("dead_first_dir", direction, 2'b01);
        check("dead_first_flag", {1'b0, dead_active}, 2'b01);
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (direction !== 2'b01 || dead_active !== 1'b1) bad = 1'b1;
        end
        check("dead_10_cycles", {1'b0, bad}, 2'b00);
        step(1);
        check("post_dead_halt_dir", direction, 2'b01);
        check("post_dead_halt_flag", {1'b0, dead_active}, 2'b00);
        step(1);
        check("rev_dir", direction, 2'b00);

        // Reset pulse mid-DEAD
        rev_req = 1'b0;
        fwd_req = 1'b1;
        step(9);
        check("dead2_flag", {1'b0, dead_active}, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_dir", direction, 2'b01);
        check("async_rst_dead", {1'b0, dead_active}, 2'b00);
        step(1);
        rst = 1'b0;
        step(7);
        check("rst_redeb_7", direction, 2'b01);
        step(1);
        check("rst_redeb_8", direction, 2'b11);

`ifdef MOTOR_WATCHDOG_EN
        // FWD state began one edge before the output changed; timeout after 50 FWD cycles
        step(49);
        check("wdt_before", direction, 2'b11);
        step(1);
        check("wdt_halt", direction, 2'b01);
        check("wdt_trip_set", {1'b0, wdt_trip}, 2'b01);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (direction !== 2'b01 || wdt_trip !== 1'b1) bad = 1'b1;
        end
        check("wdt_lockout", {1'b0, bad}, 2'b00);
        fwd_req = 1'b0;
        step(6);
        check("wdt_trip_hold", {1'b0, wdt_trip}, 2'b01);
        step(1);
        check("wdt_trip_clear", {1'b0, wdt_trip}, 2'b00);
        fwd_req = 1'b1;
        step(8);
        check("wdt_rearm_fwd", direction, 2'b11);
`else
        step(60);
        check("no_wdt_dir", direction, 2'b11);
        check("no_wdt_trip", {1'b0, wdt_trip}, 2'b00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/motor_cmd_ctrl.md
MOTOR_CMD_CTRL -- requirements
Module: motor_cmd_ctrl

Interface
- REQ-001: Parameter DEB_CYCLES, default 500, is the number of cycles a synchronized request must be stable before acceptance (5 ms at 100 kHz).
- REQ-002: Parameter DEAD_CYCLES, default 20000, is the forced-halt dead time on every direction reversal (200 ms).
- REQ-003: Parameter WDT_CYCLES, default 100000, is the keepalive timeout (1 s); it is used only when MOTOR_WATCHDOG_EN is defined.
- REQ-004: Port clk_100kHz, input, 1 bit, is the single clock, rising-edge active.
- REQ-005: Port rst, input, 1 bit, is the reset: asynchronous, active-high.
- REQ-006: Port fwd_req, input, 1 bit, is the raw asynchronous forward request level.
- REQ-007: Port rev_req, input, 1 bit, is the raw asynchronous reverse request level.
- REQ-008: Port kick, input, 1 bit, is the raw asynchronous watchdog keepalive; each rising edge counts as a kick.
- REQ-009: Port direction, output, 2 bits, is the registered motor command: 2'b11 forward, 2'b00 backward, 2'b01 halt.
- REQ-010: Port dead_active, output, 1 bit, is high while in the DEAD state.
- REQ-011: Port wdt_trip, output, 1 bit, is a sticky watchdog-timeout flag.

Function
- REQ-012: fwd_req, rev_req and kick SHALL each pass through a 2-flop synchronizer before any use.
- REQ-013: Each synchronized request SHALL be debounced; the debounced value updates only after DEB_CYCLES consecutive equal samples, and any glitch restarts the count.
- REQ-014: Intent SHALL be decoded from the debounced requests: fwd only gives FWD, rev only gives REV, and both or neither gives HALT.
- REQ-015: The FSM states SHALL be HALT, FWD, REV and DEAD, with an internal target register (FWD/REV).
- REQ-016: In HALT, intent FWD SHALL go to FWD and intent REV SHALL go to REV.
- REQ-017: In FWD, intent HALT SHALL go to HALT; intent REV SHALL go to DEAD with target=REV and the dead counter loaded with DEAD_CYCLES-1. REV behaves symmetrically.
- REQ-018: In DEAD, the dead counter SHALL decrement once per cycle; when it is at 0 the FSM goes to HALT, ignoring intent; HALT then re-evaluates intent on the next cycle.
- REQ-019: Intent changes during DEAD SHALL neither shorten nor extend the dead time.
- REQ-020: direction SHALL be registered from the state: FWD gives 11, REV gives 00, and HALT or DEAD gives 01.
- REQ-021: Latency from a raw request edge to a direction change SHALL be 2 (sync) + DEB_CYCLES (debounce) + 1 (FSM) + 1 (output register) cycles when no dead time applies.
- REQ-022: Counter widths SHALL be $clog2 of their parameter; counters SHALL saturate at 0 and never wrap.

Reset
- REQ-023: While rst=1, the FSM SHALL be in HALT, direction=2'b01, and dead_active=0, wdt_trip=0.
- REQ-024: While rst=1, synchronizers and debounced values SHALL be 0, the debounce and dead counters 0, and the watchdog counter WDT_CYCLES-1.
- REQ-025: Reset asserted mid-DEAD or mid-motion SHALL force halt immediately (asynchronously), with no pending reversal retained.

Configuration
- REQ-026: With MOTOR_WATCHDOG_EN defined, the watchdog counter SHALL reload on each synchronized kick rising edge and on entry to FWD/REV, and decrement while in FWD or REV.
- REQ-027: With MOTOR_WATCHDOG_EN defined, reaching 0 SHALL force HALT and set wdt_trip; wdt_trip and the lockout of FWD/REV clear only when intent becomes HALT.
- REQ-028: Without MOTOR_WATCHDOG_EN, the watchdog logic SHALL be absent, kick SHALL be ignored, and wdt_trip SHALL be tied to 0.

Structure
- REQ-029: Shared package motor_pkg SHALL hold the direction encodings (DIR_FWD=2'b11, DIR_REV=2'b00, DIR_HALT=2'b01) and the FSM state typedef; the MOTOR block consumes the same encodings.
- REQ-030: One sub-module, motor_debounce (synchronizer plus stability counter, parameter DEB_CYCLES), SHALL be instantiated three times.

Verification (DEB_CYCLES=4, DEAD_CYCLES=10, WDT_CYCLES=50)
- REQ-031: Reset release, then fwd_req=1 held: direction goes 01 to 11 exactly 8 cycles after the fwd_req edge.
- REQ-032: fwd_req pulses of 3 cycles, repeated: direction stays 01 throughout.
- REQ-033: In FWD, switch to rev_req=1 only: DEAD lasts 10 cycles with direction=01 and dead_active=1, then 1 HALT cycle, then direction=00.
- REQ-034: Both requests high in FWD: direction returns to 01 with no DEAD entry.
- REQ-035: Watchdog enabled, FWD with no kick: HALT and wdt_trip=1 after 50 cycles; wdt_trip persists until requests drop, and FWD is not re-entered while fwd_req stays high.
- REQ-036: rst pulse mid-DEAD: direction=01 asynchronously and dead_active=0; after release the block re-debounces before any motion.
